fcl_wght_mac: RTL and testbench
===============================

# fcl_wght_mac

Per-window multiply-accumulate engine for the first LeNet layer. Consumes the weight register bank filled from the weight SRAMs (NUM_FILTER filters × RAM_DEPTH rows × RAM_WIDTH bits) and a streamed 5×5 activation window, one row per beat. Produces NUM_FILTER signed accumulations per window through a valid/ready output handshake.

## Interface
Parameters:
- NUM_FILTER, 6, number of filters / parallel accumulators
- RAM_DEPTH, 5, rows per kernel (beats per window)
- RAM_WIDTH, 40, bits per kernel row and per activation row
- PIX_WIDTH, 8, bits per weight / pixel; PIX_PER_ROW = RAM_WIDTH/PIX_WIDTH
- CNT_WIDTH, 3, row counter width
- ACC_WIDTH, 22, accumulator width (17-bit product + 5 guard bits)

Ports:
- fcl_mac_clk  in  1  clock
- fcl_mac_rst  in  1  reset; one clock, asynchronous, active-high
- wght_i  in  NUM_FILTER×RAM_DEPTH×RAM_WIDTH  packed weight bank; wght_i[f][r] is row r of filter f
- wght_vld_i  in  1  weight bank complete (driven from the reg-write counter done)
- start_i  in  1  begin a window
- act_row_i  in  RAM_WIDTH  activation row; pixel k at [PIX_WIDTH*k +: PIX_WIDTH], unsigned
- act_valid_i  in  1  act_row_i valid
- act_ready_o  out  1  engine accepts a row
- out_data_o  out  NUM_FILTER×ACC_WIDTH  out_data_o[f] = result of filter f, two's complement
- out_valid_o  out  1  results valid
- out_ready_i  in  1  consumer takes results
- busy_o  out  1  state != IDLE

## Operation
- Weights are signed PIX_WIDTH; pixels are unsigned PIX_WIDTH, zero-extended before signed multiply; each product is 17 bits signed and sign-extended to ACC_WIDTH; no saturation, wrap modulo 2^ACC_WIDTH.
- States: IDLE, ACCUM, OUT.
- IDLE: act_ready_o=0. start_i && wght_vld_i -> clear all accumulators, row_cnt=0, go to ACCUM. start_i without wght_vld_i is ignored (no latching).
- ACCUM: act_ready_o=1. On act_valid_i && act_ready_o: acc[f] += Σk wght_i[f][row_cnt].pix[k] × act_row_i.pix[k] for all f; row_cnt++. Beat accepted with row_cnt==RAM_DEPTH-1 -> OUT, row_cnt=0. No beat -> hold.
- OUT: out_valid_o=1, out_data_o=acc (stable until handshake). On out_ready_i: if start_i && wght_vld_i in the same cycle, clear accumulators and go to ACCUM; otherwise go to IDLE.
- start_i in ACCUM or OUT (other than the OUT-handshake case) is ignored.
- wght_i must stay stable from start through the final beat; it is read combinationally and is not captured.
- Reset mid-window discards the partial sums.

## Timing
- Reset values: state IDLE, row_cnt 0, all acc 0, act_ready_o 0, out_valid_o 0, busy_o 0, out_data_o 0.
- start accepted at cycle N -> act_ready_o high at N+1.
- One row per cycle at full throughput; final beat at cycle M -> out_valid_o at M+1.
- Minimum window period with back-to-back starts at handshake: RAM_DEPTH+1 cycles.
- act_ready_o and out_valid_o are registered state decodes with no combinational path from inputs.

## Configuration
- FCL_MAC_RELU_EN defined: out_data_o[f] = 0 when acc[f] is negative, else acc[f]. Accumulators stay signed internally.
- FCL_MAC_RELU_EN undefined: raw signed acc is presented.

## Structure
- Package fcl_pkg holds PIX_WIDTH, ACC_WIDTH, the state enum (IDLE/ACCUM/OUT), and a row-word typedef.
- Sub-module fcl_row_dot is a combinational PIX_PER_ROW-term signed×unsigned dot product, instantiated NUM_FILTER times via generate.

## Test plan
- Reset, then start with wght_vld_i=0 -> act_ready_o stays 0 and busy_o stays 0.
- All weights +1, all pixels 1, 5 back-to-back beats -> out_valid_o one cycle after the last beat, every out_data_o[f]=25.
- Filter 0 weights all -128, pixels all 255 -> out_data_o[0] = -816000. With FCL_MAC_RELU_EN defined -> 0.
- act_valid_i gapped (beat, 2 idle cycles, repeat) -> same result as back-to-back, and row_cnt holds during the gaps.
- out_ready_i held low 10 cycles -> out_data_o stable and act_ready_o=0. Raise out_ready_i together with start_i -> ACCUM next cycle with cleared accumulators.
- Assert fcl_mac_rst after 3 beats -> all outputs at reset values immediately. A new window then gives a fresh result with no residue.

Source files
------------

// File: rtl/fcl_pkg.sv
// Shared constants and types for the first-layer weight MAC engine.
package fcl_pkg;

  localparam int unsigned PIX_WIDTH = 8;
  localparam int unsigned ACC_WIDTH = 22;
  localparam int unsigned RAM_WIDTH = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } fcl_state_e;

  typedef logic [RAM_WIDTH-1:0] fcl_row_t;

endpackage

// File: rtl/fcl_row_dot.sv
// Combinational dot product of one signed weight row with one unsigned pixel row.
module fcl_row_dot
  import fcl_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_WIDTH,
  parameter int unsigned ROW_W = RAM_WIDTH,
  parameter int unsigned ACC_W = ACC_WIDTH
) (
  input  logic [ROW_W-1:0] wght_row,
  input  logic [ROW_W-1:0] act_row,
  output logic [ACC_W-1:0] dot_c
);

  localparam int unsigned NPIX   = ROW_W / PIX_W;
  localparam int unsigned PROD_W = 2 * PIX_W + 1;

  // Sum of signed weight x zero-extended pixel products, sign-extended to ACC_W.
  always_comb begin
    logic signed [PROD_W-1:0] prod;
    prod  = '0;
    dot_c = '0;
    for (int k = 0; k < int'(NPIX); k++) begin
      prod  = $signed(wght_row[k*PIX_W +: PIX_W]) * $signed({1'b0, act_row[k*PIX_W +: PIX_W]});
      dot_c = dot_c + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/fcl_wght_mac.sv
// Per-window multiply-accumulate engine: NUM_FILTER kernels over a streamed window.
// Optional build macro FCL_MAC_RELU_EN clamps negative results to zero at the output.
module fcl_wght_mac #(
  parameter int unsigned NUM_FILTER = 6,
  parameter int unsigned RAM_DEPTH  = 5,
  parameter int unsigned RAM_WIDTH  = 40,
  parameter int unsigned PIX_WIDTH  = fcl_pkg::PIX_WIDTH,
  parameter int unsigned CNT_WIDTH  = 3,
  parameter int unsigned ACC_WIDTH  = fcl_pkg::ACC_WIDTH
) (
  input  logic                                             fcl_mac_clk,
  input  logic                                             fcl_mac_rst,
  input  logic [NUM_FILTER-1:0][RAM_DEPTH-1:0][RAM_WIDTH-1:0] wght_i,
  input  logic                                             wght_vld_i,
  input  logic                                             start_i,
  input  logic [RAM_WIDTH-1:0]                             act_row_i,
  input  logic                                             act_valid_i,
  output logic                                             act_ready_o,
  output logic [NUM_FILTER-1:0][ACC_WIDTH-1:0]             out_data_o,
  output logic                                             out_valid_o,
  input  logic                                             out_ready_i,
  output logic                                             busy_o
);

  import fcl_pkg::*;

  fcl_state_e                           state_q, state_d;
  logic [CNT_WIDTH-1:0]                 row_cnt_q, row_cnt_d;
  logic [NUM_FILTER-1:0][ACC_WIDTH-1:0] acc_q, acc_d, out_d;
  logic [ACC_WIDTH-1:0]                 dot_c [NUM_FILTER];
  logic                                 start_ok_c;
  logic                                 beat_c;

  assign start_ok_c = start_i & wght_vld_i;
  assign beat_c     = act_valid_i & act_ready_o;

  // One row dot product per filter, selected by the current row counter.
  for (genvar f = 0; f < int'(NUM_FILTER); f++) begin : g_dot
    fcl_row_dot #(
      .PIX_W (PIX_WIDTH),
      .ROW_W (RAM_WIDTH),
      .ACC_W (ACC_WIDTH)
    ) u_dot (
      .wght_row (wght_i[f][row_cnt_q]),
      .act_row  (act_row_i),
      .dot_c    (dot_c[f])
    );
  end

  // Next-state, row counter and accumulator update.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    acc_d     = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok_c) begin
          acc_d     = '0;
          row_cnt_d = '0;
          state_d   = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat_c) begin
          for (int f = 0; f < int'(NUM_FILTER); f++) begin
            acc_d[f] = acc_q[f] + dot_c[f];
          end
          if (row_cnt_q == CNT_WIDTH'(RAM_DEPTH - 1)) begin
            row_cnt_d = '0;
            state_d   = ST_OUT;
          end else begin
            row_cnt_d = row_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      ST_OUT: begin
        if (out_ready_i) begin
          if (start_ok_c) begin
            acc_d     = '0;
            row_cnt_d = '0;
            state_d   = ST_ACCUM;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output value presented for each filter (optionally rectified).
  always_comb begin
    out_d = acc_d;
`ifdef FCL_MAC_RELU_EN
    for (int f = 0; f < int'(NUM_FILTER); f++) begin
      if (acc_d[f][ACC_WIDTH-1]) out_d[f] = '0;
    end
`else
`endif
  end

  // State, counter and accumulator registers.
  always_ff @(posedge fcl_mac_clk or posedge fcl_mac_rst) begin
    if (fcl_mac_rst) begin
      state_q   <= ST_IDLE;
      row_cnt_q <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      acc_q     <= acc_d;
    end
  end

  // Registered handshake/status decodes and result word.
  always_ff @(posedge fcl_mac_clk or posedge fcl_mac_rst) begin
    if (fcl_mac_rst) begin
      act_ready_o <= 1'b0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      out_data_o  <= '0;
    end else begin
      act_ready_o <= (state_d == ST_ACCUM);
      out_valid_o <= (state_d == ST_OUT);
      busy_o      <= (state_d != ST_IDLE);
      out_data_o  <= out_d;
    end
  end

endmodule

// File: tb/tb_fcl_wght_mac.sv
// Directed + randomized self-checking bench for fcl_wght_mac.
module tb_fcl_wght_mac;

  import fcl_pkg::*;

  localparam int unsigned NF   = 6;
  localparam int unsigned RD   = 5;
  localparam int unsigned RW   = 40;
  localparam int unsigned PW   = 8;
  localparam int unsigned AW   = 22;
  localparam int unsigned NPIX = RW / PW;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [NF-1:0][RD-1:0][RW-1:0] wght;
  logic                         wght_vld = 1'b0;
  logic                         start = 1'b0;
  logic [RW-1:0]                act_row = '0;
  logic                         act_valid = 1'b0;
  logic                         act_ready;
  logic [NF-1:0][AW-1:0]        out_data;
  logic                         out_valid;
  logic                         out_ready = 1'b0;
  logic                         busy;

  fcl_row_t rows [RD];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fcl_wght_mac #(
    .NUM_FILTER (NF),
    .RAM_DEPTH  (RD),
    .RAM_WIDTH  (RW),
    .PIX_WIDTH  (PW),
    .CNT_WIDTH  (3),
    .ACC_WIDTH  (AW)
  ) dut (
    .fcl_mac_clk (clk),
    .fcl_mac_rst (rst),
    .wght_i      (wght),
    .wght_vld_i  (wght_vld),
    .start_i     (start),
    .act_row_i   (act_row),
    .act_valid_i (act_valid),
    .act_ready_o (act_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy)
  );

  // Reference: plain integer convolution of the whole window for filter f.
  function automatic logic [AW-1:0] model(input int f);
    int s;
    s = 0;
    for (int r = 0; r < int'(RD); r++) begin
      for (int k = 0; k < int'(NPIX); k++) begin
        logic [PW-1:0] wb;
        logic [PW-1:0] pb;
        wb = wght[f][r][PW*k +: PW];
        pb = rows[r][PW*k +: PW];
        s += int'($signed(wb)) * int'(pb);
      end
    end
`ifdef FCL_MAC_RELU_EN
    if (s < 0) s = 0;
`endif
    return AW'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_data();
    for (int f = 0; f < int'(NF); f++)
      for (int r = 0; r < int'(RD); r++)
        wght[f][r] = RW'({$urandom(), $urandom()});
    for (int r = 0; r < int'(RD); r++)
      rows[r] = RW'({$urandom(), $urandom()});
  endtask

  task automatic do_start();
    start    = 1'b1;
    wght_vld = 1'b1;
    tick();
    start    = 1'b0;
    chk("ready_after_start", 32'(act_ready), 32'd1);
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic feed(input int gap);
    for (int r = 0; r < int'(RD); r++) begin
      act_row   = rows[r];
      act_valid = 1'b1;
      tick();
      act_valid = 1'b0;
      act_row   = RW'({$urandom(), $urandom()});
      if (r < int'(RD) - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("gap_no_valid", 32'(out_valid), 32'd0);
          chk("gap_ready", 32'(act_ready), 32'd1);
        end
      end
    end
    chk("valid_after_last", 32'(out_valid), 32'd1);
    chk("ready_low_in_out", 32'(act_ready), 32'd0);
  endtask

  task automatic chk_res(input string tag);
    for (int f = 0; f < int'(NF); f++)
      chk($sformatf("%s_f%0d", tag, f), 32'(out_data[f]), 32'(model(f)));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_after_take", 32'(out_valid), 32'd0);
    chk("idle_after_take", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] lit;
    wght = '0;
    for (int r = 0; r < int'(RD); r++) rows[r] = '0;

    // Reset values
    tick();
    tick();
    chk("rst_ready", 32'(act_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(out_data[0]), 32'd0);
    rst = 1'b0;

    // start without weight bank valid is ignored
    start    = 1'b1;
    wght_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("novld_ready", 32'(act_ready), 32'd0);
      chk("novld_busy", 32'(busy), 32'd0);
    end
    start = 1'b0;
    tick();

    // All-ones kernel and window
    for (int f = 0; f < int'(NF); f++)
      for (int r = 0; r < int'(RD); r++)
        wght[f][r] = {5{8'h01}};
    for (int r = 0; r < int'(RD); r++) rows[r] = {5{8'h01}};
    do_start();
    feed(0);
    chk_res("ones");
    for (int f = 0; f < int'(NF); f++)
      chk("ones_25", 32'(out_data[f]), 32'd25);
    release_out();

    // Most negative kernel on filter 0 against saturated pixels
    randomize_data();
    for (int r = 0; r < int'(RD); r++) begin
      wght[0][r] = {5{8'h80}};
      rows[r]    = {5{8'hff}};
    end
    do_start();
    feed(0);
    chk_res("neg");
`ifdef FCL_MAC_RELU_EN
    lit = '0;
`else
    lit = AW'(-816000);
`endif
    chk("neg_literal", 32'(out_data[0]), 32'(lit));
    release_out();

    // Random windows, alternating back-to-back and gapped beats
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) randomize_data();
      do_start();
      feed((i % 2 == 0) ? 0 : 2);
      chk_res($sformatf("rand%0d", i));
      release_out();
    end

    // Consumer stall: result held, then restart in the handshake cycle
    randomize_data();
    do_start();
    feed(0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(act_ready), 32'd0);
      chk_res("hold");
    end
    randomize_data();
    out_ready = 1'b1;
    start     = 1'b1;
    wght_vld  = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("restart_ready", 32'(act_ready), 32'd1);
    chk("restart_valid", 32'(out_valid), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    feed(0);
    chk_res("restart");
    release_out();

    // Reset after three beats, then a clean window
    randomize_data();
    do_start();
    for (int r = 0; r < 3; r++) begin
      act_row   = rows[r];
      act_valid = 1'b1;
      tick();
    end
    act_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(act_ready), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int f = 0; f < int'(NF); f++)
      chk("midrst_data", 32'(out_data[f]), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    randomize_data();
    do_start();
    feed(0);
    chk_res("post_rst");
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
